// File: rtl/muldiv_pkg.sv
// Shared encodings for the MIPS32 multiply/divide unit: op codes, FSM states
// and HI/LO write-enable patterns.
package muldiv_pkg;

  localparam int MD_WIDTH = 32;

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PREP,
    ST_ITER,
    ST_FIX
  } md_state_t;

  localparam logic [1:0] WE_NONE = 2'b00;
  localparam logic [1:0] WE_HI   = 2'b10;
  localparam logic [1:0] WE_LO   = 2'b01;
  localparam logic [1:0] WE_BOTH = 2'b11;

endpackage

// File: rtl/muldiv_iter_core.sv
// One iteration step shared by multiply (shift-add) and divide (restoring).
// The accumulator is {acc_hi, acc_lo}; acc_lo holds the multiplier or dividend bits.
module muldiv_iter_core #(
  parameter int WIDTH = 32
) (
  input  logic             div_mode,
  input  logic [WIDTH-1:0] acc_hi,
  input  logic [WIDTH-1:0] acc_lo,
  input  logic [WIDTH-1:0] operand,
  output logic [WIDTH-1:0] acc_hi_next,
  output logic [WIDTH-1:0] acc_lo_next,
  output logic             q_bit
);

  logic [WIDTH:0] add_sum;
  logic [WIDTH:0] rem_shift;
  logic [WIDTH:0] trial;

  always_comb begin
    add_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, operand} : {(WIDTH+1){1'b0}});
    rem_shift = {acc_hi, acc_lo[WIDTH-1]};
    trial     = rem_shift - {1'b0, operand};
    q_bit     = 1'b0;
    if (div_mode) begin
      // A non-negative trial difference means the divisor fits: keep it.
      q_bit       = ~trial[WIDTH];
      acc_hi_next = q_bit ? trial[WIDTH-1:0] : rem_shift[WIDTH-1:0];
      acc_lo_next = {acc_lo[WIDTH-2:0], 1'b0};
    end else begin
      acc_hi_next = add_sum[WIDTH:1];
      acc_lo_next = {add_sum[0], acc_lo[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit with MTHI/MTLO forwarding; drives the
// HI/LO register file through registered hi_o/lo_o/we_o.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH = MD_WIDTH,
  parameter int OP_W  = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic [OP_W-1:0]  op_i,
  input  logic [WIDTH-1:0] rs_i,
  input  logic [WIDTH-1:0] rt_i,
  input  logic             flush_i,
  output logic             busy_o,
  output logic [1:0]       we_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);

  localparam int CNT_W = $clog2(WIDTH) + 1;

  md_state_t        state_q, state_d;
  logic [WIDTH-1:0] acc_hi_q, acc_hi_d;
  logic [WIDTH-1:0] acc_lo_q, acc_lo_d;
  logic [WIDTH-1:0] opnd_q, opnd_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             is_div_q, is_div_d;
  logic             is_signed_q, is_signed_d;
  logic             neg_quo_q, neg_quo_d;
  logic             neg_rem_q, neg_rem_d;
  logic [1:0]       we_q, we_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;

  logic [WIDTH-1:0]   step_hi;
  logic [WIDTH-1:0]   step_lo;
  logic               step_q;
  logic               sign_a;
  logic               sign_b;
  logic [2*WIDTH-1:0] prod_raw;
  logic [2*WIDTH-1:0] prod_fix;

  muldiv_iter_core #(.WIDTH(WIDTH)) u_core (
    .div_mode    (is_div_q),
    .acc_hi      (acc_hi_q),
    .acc_lo      (acc_lo_q),
    .operand     (opnd_q),
    .acc_hi_next (step_hi),
    .acc_lo_next (step_lo),
    .q_bit       (step_q)
  );

  always_comb begin
    state_d     = state_q;
    acc_hi_d    = acc_hi_q;
    acc_lo_d    = acc_lo_q;
    opnd_d      = opnd_q;
    count_d     = count_q;
    is_div_d    = is_div_q;
    is_signed_d = is_signed_q;
    neg_quo_d   = neg_quo_q;
    neg_rem_d   = neg_rem_q;
    we_d        = WE_NONE;
    hi_d        = hi_q;
    lo_d        = lo_q;
    sign_a      = is_signed_q & acc_lo_q[WIDTH-1];
    sign_b      = is_signed_q & opnd_q[WIDTH-1];
    prod_raw    = {acc_hi_q, acc_lo_q};
    prod_fix    = neg_quo_q ? -prod_raw : prod_raw;

    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          case (op_i)
            OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
              acc_lo_d    = rs_i;
              opnd_d      = rt_i;
              is_div_d    = (op_i == OP_DIV) || (op_i == OP_DIVU);
              is_signed_d = (op_i == OP_MULT) || (op_i == OP_DIV);
              state_d     = ST_PREP;
            end
            OP_MTHI: begin
              we_d = WE_HI;
              hi_d = rs_i;
            end
            OP_MTLO: begin
              we_d = WE_LO;
              lo_d = rs_i;
            end
            default: ;
          endcase
        end
      end
      ST_PREP: begin
        acc_hi_d  = '0;
        acc_lo_d  = sign_a ? -acc_lo_q : acc_lo_q;
        opnd_d    = sign_b ? -opnd_q : opnd_q;
        neg_quo_d = sign_a ^ sign_b;
        neg_rem_d = sign_a;
        count_d   = CNT_W'(WIDTH);
        state_d   = ST_ITER;
        // Divide by zero skips iteration: quotient all-ones, remainder = raw dividend.
        if (is_div_q && (opnd_q == '0)) begin
          acc_hi_d  = acc_lo_q;
          acc_lo_d  = '1;
          neg_quo_d = 1'b0;
          neg_rem_d = 1'b0;
          state_d   = ST_FIX;
        end
      end
      ST_ITER: begin
        acc_hi_d = step_hi;
        acc_lo_d = {step_lo[WIDTH-1:1], step_lo[0] | step_q};
        count_d  = count_q - 1'b1;
        if (count_q == CNT_W'(1)) begin
          state_d = ST_FIX;
        end
      end
      ST_FIX: begin
        if (is_div_q) begin
          lo_d = neg_quo_q ? -acc_lo_q : acc_lo_q;
          hi_d = neg_rem_q ? -acc_hi_q : acc_hi_q;
        end else begin
          {hi_d, lo_d} = prod_fix;
        end
        we_d    = WE_BOTH;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // Flush wins over everything, including a same-cycle start or the final write.
    if (flush_i) begin
      state_d = ST_IDLE;
      we_d    = WE_NONE;
      hi_d    = hi_q;
      lo_d    = lo_q;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      acc_hi_q    <= '0;
      acc_lo_q    <= '0;
      opnd_q      <= '0;
      count_q     <= '0;
      is_div_q    <= 1'b0;
      is_signed_q <= 1'b0;
      neg_quo_q   <= 1'b0;
      neg_rem_q   <= 1'b0;
      we_q        <= WE_NONE;
      hi_q        <= '0;
      lo_q        <= '0;
    end else begin
      state_q     <= state_d;
      acc_hi_q    <= acc_hi_d;
      acc_lo_q    <= acc_lo_d;
      opnd_q      <= opnd_d;
      count_q     <= count_d;
      is_div_q    <= is_div_d;
      is_signed_q <= is_signed_d;
      neg_quo_q   <= neg_quo_d;
      neg_rem_q   <= neg_rem_d;
      we_q        <= we_d;
      hi_q        <= hi_d;
      lo_q        <= lo_d;
    end
  end

  assign busy_o = (state_q != ST_IDLE);
  assign we_o   = we_q;
  assign hi_o   = hi_q;
  assign lo_o   = lo_q;

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Iterative multiply/divide unit for the MIPS32 execute stage.
- Computes MULT, MULTU, DIV and DIVU results, and forwards MTHI/MTLO operands.
- Output hi_o/lo_o/we_o drives the HI/LO register file directly: we_o[1] writes HI, we_o[0] writes LO.
- The pipeline control stalls on busy_o; a flush input cancels an in-flight operation after an exception.

Parameters:
- WIDTH, 32, operand and result width; iteration count equals WIDTH.
- OP_W, 3, width of op_i encoding.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-low reset.
- start_i  input  1  launch request; sampled only when busy_o=0.
- op_i  input  3  0=MULT, 1=MULTU, 2=DIV, 3=DIVU, 4=MTHI, 5=MTLO, others=no-op.
- rs_i  input  WIDTH  operand A: multiplicand, dividend, or MTHI/MTLO source.
- rt_i  input  WIDTH  operand B: multiplier or divisor.
- flush_i  input  1  cancel the in-flight operation, no HI/LO write.
- busy_o  output  1  high while an operation is in progress; pipeline stalls on it.
- we_o  output  2  one-cycle HI/LO write strobe.
- hi_o  output  WIDTH  HI write data.
- lo_o  output  WIDTH  LO write data.

Behaviour:
- Reset (rst=0, async): state=IDLE; busy_o=0; we_o=00; hi_o=0; lo_o=0; all internal registers cleared.
- we_o is 00 on every cycle except the single result cycle.
- hi_o/lo_o hold their last values between results.
- FSM states: IDLE, PREP, ITER, FIX.
- IDLE, start_i=1 with MTHI or MTLO:
  - Next cycle we_o=10 with hi_o=rs_i (MTHI), or we_o=01 with lo_o=rs_i (MTLO).
  - FSM stays in IDLE; busy_o stays 0; latency 1.
- IDLE, start_i=1 with op 0-3:
  - Latch op, rs_i, rt_i; go to PREP; busy_o=1 from the next cycle.
- IDLE, start_i=1 with op 6-7: ignored.
- PREP (1 cycle):
  - Signed ops: take absolute values of both operands and record result signs.
  - Quotient sign = sA^sB; remainder sign = sA.
  - Clear the accumulator and set count=WIDTH.
  - Divide with divisor=0: go directly to FIX with lo=all-ones and hi=raw rs (signed and unsigned alike).
  - Otherwise go to ITER.
- ITER (WIDTH cycles):
  - Multiply: radix-2 shift-add, one multiplier bit per cycle, into a 2*WIDTH-bit product.
  - Divide: restoring; shift the remainder left by 1, trial-subtract the divisor, set the quotient bit when the result is non-negative.
  - count decrements each cycle; go to FIX when count reaches 1.
- FIX (1 cycle):
  - Apply two's-complement sign correction.
  - Multiply: {hi,lo} = 64-bit product.
  - Divide: lo=quotient, hi=remainder.
  - Drive we_o=11 for exactly this cycle's registered output, then return to IDLE; busy_o drops the same cycle we_o=11.
- Latency:
  - start at edge T; we_o=11 visible after edge T+WIDTH+2 (34 cycles for WIDTH=32).
  - Divide-by-zero: visible after T+2.
- Width rules:
  - MULT/MULTU produce the full 64-bit product with no overflow.
  - Signed -2^31 * -2^31 = 0x40000000_00000000.
  - DIV of 0x80000000 by -1: quotient 0x80000000, remainder 0 (wraps).
- start_i while busy_o=1: ignored; the issuing stage must hold the request.
- flush_i=1 in any state: return to IDLE next cycle, busy_o=0, no we_o pulse.
  - flush_i in FIX suppresses the write.
  - flush_i has priority over start_i in the same cycle.
- Reset mid-operation: immediate return to reset values; no partial write.

Decomposition:
- Package muldiv_pkg:
  - op encodings (OP_MULT..OP_MTLO).
  - FSM state enum.
  - WE_HI/WE_LO/WE_BOTH constants.
  - WIDTH default.
- Sub-module: muldiv_iter_core, one shift/add-subtract step shared by multiply and divide. It takes the accumulator, operand, and a mode bit, and returns the next accumulator and quotient bit.
- The top module holds the FSM, sign handling and output registers.

Test Plan:
- MULTU rs=0xFFFFFFFF, rt=0xFFFFFFFF -> 34 cycles later we_o=11, hi=0xFFFFFFFE, lo=0x00000001; busy_o high for 34 cycles.
- MULT rs=0xFFFFFFFE (-2), rt=3 -> hi=0xFFFFFFFF, lo=0xFFFFFFFA.
- DIV rs=-7 (0xFFFFFFF9), rt=2 -> lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1).
- DIVU rs=100, rt=7 -> lo=14, hi=2.
- DIVU rs=0x1234, rt=0 -> after 2 cycles we_o=11, lo=0xFFFFFFFF, hi=0x1234.
- MTHI rs=0xDEADBEEF -> next cycle we_o=10, hi_o=0xDEADBEEF, busy_o stays 0.
- MULT started, flush_i at iteration 10 -> busy_o=0 next cycle, we_o never asserted.
- Then DIVU 9/3 -> lo=3, hi=0.
- rst low during ITER -> all outputs 0 asynchronously.
